lutram_access_ctrl: RTL and testbench

//  Sequences and shares one simple-dual-port LUTRAM (1 write port, 1 registered read port).

---
 rtl/lutram_ctrl_pkg.sv | 30 +++
 rtl/lutram_access_ctrl_if.sv | 46 ++++
 rtl/lutram_access_ctrl_arb.sv | 38 +++
 rtl/lutram_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_lutram_access_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lutram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lutram_ctrl_pkg
// Brief    : Shared types and helpers for the LUTRAM access controller.
// Revision : 1.0 - initial release
// ============================================================================
package lutram_ctrl_pkg;

    localparam int LUTRAM_MAX_ADDR_W = 32;
    localparam int LUTRAM_MAX_DATA_W = 1024;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_t;

    // Sized to the largest supported bus; instances truncate to their own widths.
    typedef struct packed {
        logic                         valid;
        logic [LUTRAM_MAX_ADDR_W-1:0] addr;
        logic [LUTRAM_MAX_DATA_W-1:0] data;
    } lutram_wr_req_t;

    function automatic int unsigned entry_count(input int unsigned depth_exp2);
        return 32'd1 << depth_exp2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lutram_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lutram_access_ctrl_if
// Brief    : Requester-side bus of the controller: two write ports, one read port.
// Revision : 1.0 - initial release
// ============================================================================
interface lutram_access_ctrl_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 8
) ();

    logic                  wr0_valid_i;
    logic [ADDR_WIDTH-1:0] wr0_addr_i;
    logic [DATA_WIDTH-1:0] wr0_data_i;
    logic                  wr0_ready_o;

    logic                  wr1_valid_i;
    logic [ADDR_WIDTH-1:0] wr1_addr_i;
    logic [DATA_WIDTH-1:0] wr1_data_i;
    logic                  wr1_ready_o;

    logic                  rd_valid_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;

    modport master (
        output wr0_valid_i, wr0_addr_i, wr0_data_i,
        input  wr0_ready_o,
        output wr1_valid_i, wr1_addr_i, wr1_data_i,
        input  wr1_ready_o,
        output rd_valid_i, rd_addr_i,
        input  rd_data_o, rd_valid_o
    );

    modport slave (
        input  wr0_valid_i, wr0_addr_i, wr0_data_i,
        output wr0_ready_o,
        input  wr1_valid_i, wr1_addr_i, wr1_data_i,
        output wr1_ready_o,
        input  rd_valid_i, rd_addr_i,
        output rd_data_o, rd_valid_o
    );

endinterface
`default_nettype wire

// File: rtl/lutram_access_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-input round-robin arbiter; pointer moves only on a grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_en,
    input  wire logic [1:0] i_req,
    output logic      [1:0] o_gnt
);

    // 1 = requester 1 was granted last, so requester 0 wins the first tie.
    logic r_last;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (&i_req) begin
                o_gnt = r_last ? 2'b01 : 2'b10;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/lutram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lutram_access_ctrl
// Brief    : Clear/flush sweeps, write arbitration and read forwarding for one
//            simple-dual-port LUTRAM. Optional macro: LUTRAM_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lutram_access_ctrl
    import lutram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = 128,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_DEPTH_EXP2 = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  flush_req_i,
    output logic                       busy_o,

    lutram_access_ctrl_if.slave        bus,

    output logic                       ram_ena_o,
    output logic                       ram_wea_o,
    output logic [ADDR_WIDTH-1:0]      ram_addra_o,
    output logic [DATA_WIDTH-1:0]      ram_dina_o,
    output logic                       ram_enb_o,
    output logic [ADDR_WIDTH-1:0]      ram_addrb_o,
    input  wire logic [DATA_WIDTH-1:0] ram_doutb_i
);

    localparam int unsigned                c_ENTRIES  = entry_count(DATA_DEPTH_EXP2);
    localparam logic [DATA_DEPTH_EXP2-1:0] c_CNT_LAST = DATA_DEPTH_EXP2'(c_ENTRIES - 1);
    localparam logic [DATA_DEPTH_EXP2-1:0] c_CNT_ONE  = DATA_DEPTH_EXP2'(1);

    ctrl_state_t                r_state;
    ctrl_state_t                w_state_nxt;
    logic [DATA_DEPTH_EXP2-1:0] r_cnt;
    logic [DATA_DEPTH_EXP2-1:0] w_cnt_nxt;
    logic                       w_sweep;
    logic                       w_idle;
    logic [1:0]                 w_gnt;
    logic                       w_hs;
    logic                       r_rd_valid;
    lutram_wr_req_t             w_req0;
    lutram_wr_req_t             w_req1;
    lutram_wr_req_t             w_win;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Sweep writes are held off while reset is asserted so the RAM port stays quiet.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sweep     = 1'b0;
        case (r_state)
            CLEAR, FLUSH: begin
                w_sweep   = rst_n;
                w_cnt_nxt = r_cnt + c_CNT_ONE;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            IDLE: begin
                if (flush_req_i) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_idle = (r_state == IDLE);
    assign busy_o = ~w_idle;

    always_comb begin
        w_req0       = '0;
        w_req0.valid = bus.wr0_valid_i;
        w_req0.addr  = LUTRAM_MAX_ADDR_W'(bus.wr0_addr_i);
        w_req0.data  = LUTRAM_MAX_DATA_W'(bus.wr0_data_i);
        w_req1       = '0;
        w_req1.valid = bus.wr1_valid_i;
        w_req1.addr  = LUTRAM_MAX_ADDR_W'(bus.wr1_addr_i);
        w_req1.data  = LUTRAM_MAX_DATA_W'(bus.wr1_data_i);
    end

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_idle),
        .i_req ({w_req1.valid, w_req0.valid}),
        .o_gnt (w_gnt)
    );

    assign w_hs            = |w_gnt;
    assign w_win           = w_gnt[0] ? w_req0 : (w_gnt[1] ? w_req1 : '0);
    assign bus.wr0_ready_o = w_gnt[0];
    assign bus.wr1_ready_o = w_gnt[1];

    assign ram_ena_o   = w_sweep | w_hs;
    assign ram_wea_o   = w_sweep | w_hs;
    assign ram_addra_o = w_sweep ? ADDR_WIDTH'(r_cnt) : ADDR_WIDTH'(w_win.addr);
    assign ram_dina_o  = w_sweep ? '0 : DATA_WIDTH'(w_win.data);

    assign ram_enb_o   = bus.rd_valid_i & ~busy_o;
    assign ram_addrb_o = bus.rd_addr_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= ram_enb_o;
        end
    end

    assign bus.rd_valid_o = r_rd_valid;

`ifdef LUTRAM_BYPASS_EN
    logic                  r_byp_hit;
    logic [DATA_WIDTH-1:0] r_byp_data;

    // A same-cycle write to the read address returns the new value instead of the old one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byp_hit  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_hit  <= ram_ena_o & ram_enb_o &
                          (ram_addra_o[DATA_DEPTH_EXP2-1:0] == ram_addrb_o[DATA_DEPTH_EXP2-1:0]);
            r_byp_data <= ram_dina_o;
        end
    end

    assign bus.rd_data_o = r_byp_hit ? r_byp_data : ram_doutb_i;
`else
    assign bus.rd_data_o = ram_doutb_i;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lutram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lutram_access_ctrl
// Brief    : Scoreboard bench for lutram_access_ctrl with a registered-read RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lutram_access_ctrl;

    localparam int DW   = 128;
    localparam int AW   = 8;
    localparam int DEXP = 4;
    localparam int NENT = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_req = 1'b0;
    logic          busy;
    logic          ram_ena, ram_wea, ram_enb;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dina;
    logic [DW-1:0] doutb = '0;
    logic [DW-1:0] mem [NENT];
    logic [DW-1:0] shadow [NENT];

    wr_t           wq[$];
    logic [DW-1:0] rq[$];
    int            checks = 0;
    int            errors = 0;

    lutram_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    lutram_access_ctrl #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .DATA_DEPTH_EXP2 (DEXP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_req_i (flush_req),
        .busy_o      (busy),
        .bus         (bus),
        .ram_ena_o   (ram_ena),
        .ram_wea_o   (ram_wea),
        .ram_addra_o (ram_addra),
        .ram_dina_o  (ram_dina),
        .ram_enb_o   (ram_enb),
        .ram_addrb_o (ram_addrb),
        .ram_doutb_i (doutb)
    );

    always #5 clk = ~clk;

    // Pre-filled with a marker so a missing clear sweep is visible on readback.
    initial begin
        for (int i = 0; i < NENT; i++) mem[i] = {(DW/16){16'hDEAD}};
    end

    always @(posedge clk) begin
        if (ram_enb) doutb <= mem[ram_addrb[DEXP-1:0]];
        else         doutb <= '0;
        if (ram_ena && ram_wea) mem[ram_addra[DEXP-1:0]] <= ram_dina;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t           e;
        logic [DW-1:0] d;
        if (ram_ena === 1'b1 || ram_wea === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h with none expected", ram_addra, ram_dina);
            end else begin
                e = wq.pop_front();
                chk("wr_ena_eq_wea", DW'(ram_ena), DW'(ram_wea));
                chk("wr_addr", DW'(ram_addra), DW'(e.addr));
                chk("wr_data", ram_dina, e.data);
            end
        end
        if (bus.rd_valid_o === 1'b1) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: data %0h with none expected", bus.rd_data_o);
            end else begin
                d = rq.pop_front();
                chk("rd_data", bus.rd_data_o, d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
        shadow[a[DEXP-1:0]] = d;
    endtask

    task automatic push_sweep(input int n);
        for (int i = 0; i < n; i++) push_wr(AW'(i), '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        bus.rd_valid_i = 1'b1;
        bus.rd_addr_i  = a;
        rq.push_back(shadow[a[DEXP-1:0]]);
        tick();
        bus.rd_valid_i = 1'b0;
    endtask

    task automatic wr0_single(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr0_valid_i = 1'b1;
        bus.wr0_addr_i  = a;
        bus.wr0_data_i  = d;
        push_wr(a, d);
        @(negedge clk);
        chk("single_rdy0", DW'(bus.wr0_ready_o), DW'(1));
        chk("single_rdy1", DW'(bus.wr1_ready_o), DW'(0));
        tick();
        bus.wr0_valid_i = 1'b0;
    endtask

    task automatic wait_sweep(input string name);
        int n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk(name, DW'(n), DW'(NENT));
        tick();
    endtask

    initial begin
        int i0, i1, w, n;
        logic [DW-1:0] exp_byp;
        bus.wr0_valid_i = 1'b0; bus.wr0_addr_i = '0; bus.wr0_data_i = '0;
        bus.wr1_valid_i = 1'b0; bus.wr1_addr_i = '0; bus.wr1_data_i = '0;
        bus.rd_valid_i  = 1'b0; bus.rd_addr_i  = '0;
        for (int i = 0; i < NENT; i++) shadow[i] = '0;

        // Reset with a pending request: no grant, no RAM activity.
        bus.wr0_valid_i = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_busy", DW'(busy), DW'(1));
        chk("rst_rd_valid", DW'(bus.rd_valid_o), DW'(0));
        chk("rst_ram_ena", DW'(ram_ena), DW'(0));
        chk("rst_ram_enb", DW'(ram_enb), DW'(0));
        chk("rst_rdy0", DW'(bus.wr0_ready_o), DW'(0));
        tick();
        bus.wr0_valid_i = 1'b0;
        push_sweep(NENT);
        rst_n = 1'b1;
        wait_sweep("clear_len");

        // Tie for four cycles: wr0, wr1, wr0, wr1.
        i0 = 0;
        i1 = 0;
        bus.wr0_valid_i = 1'b1;
        bus.wr1_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.wr0_addr_i = AW'(8 + 2 * i0);
            bus.wr0_data_i = DW'(32'h100 + i0);
            bus.wr1_addr_i = AW'(9 + 2 * i1);
            bus.wr1_data_i = DW'(32'h200 + i1);
            w = k % 2;
            if (w == 0) push_wr(bus.wr0_addr_i, bus.wr0_data_i);
            else        push_wr(bus.wr1_addr_i, bus.wr1_data_i);
            @(negedge clk);
            chk("tie_rdy0", DW'(bus.wr0_ready_o), DW'(w == 0));
            chk("tie_rdy1", DW'(bus.wr1_ready_o), DW'(w == 1));
            tick();
            if (w == 0) i0++;
            else        i1++;
        end
        bus.wr0_valid_i = 1'b0;
        bus.wr1_valid_i = 1'b0;

        wr0_single(AW'(3), DW'(32'hA5));
        rd(AW'(3));
        for (int a = 8; a < 12; a++) rd(AW'(a));

        // Same-cycle write and read of one address.
        wr0_single(AW'(5), DW'(32'h22));
`ifdef LUTRAM_BYPASS_EN
        exp_byp = DW'(32'h11);
`else
        exp_byp = DW'(32'h22);
`endif
        bus.wr0_valid_i = 1'b1;
        bus.wr0_addr_i  = AW'(5);
        bus.wr0_data_i  = DW'(32'h11);
        bus.rd_valid_i  = 1'b1;
        bus.rd_addr_i   = AW'(5);
        rq.push_back(exp_byp);
        push_wr(AW'(5), DW'(32'h11));
        tick();
        bus.wr0_valid_i = 1'b0;
        bus.rd_valid_i  = 1'b0;
        rd(AW'(5));

        // Flush, a second flush and a read mid-sweep (both ignored), write held throughout.
        flush_req = 1'b1;
        push_sweep(NENT);
        tick();
        flush_req = 1'b0;
        bus.wr0_valid_i = 1'b1;
        bus.wr0_addr_i  = AW'(2);
        bus.wr0_data_i  = DW'(32'h33);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (!busy) break;
            n++;
            if (n == 5) begin
                flush_req      = 1'b1;
                bus.rd_valid_i = 1'b1;
                bus.rd_addr_i  = AW'(3);
            end else begin
                flush_req      = 1'b0;
                bus.rd_valid_i = 1'b0;
            end
            tick();
        end
        flush_req      = 1'b0;
        bus.rd_valid_i = 1'b0;
        chk("flush_len", DW'(n), DW'(NENT));
        push_wr(AW'(2), DW'(32'h33));
        @(negedge clk);
        chk("post_flush_rdy0", DW'(bus.wr0_ready_o), DW'(1));
        tick();
        bus.wr0_valid_i = 1'b0;
        rd(AW'(3));
        rd(AW'(8));
        rd(AW'(2));

        // Reset lands when the flush counter reaches 7.
        flush_req = 1'b1;
        push_sweep(7);
        tick();
        flush_req = 1'b0;
        bus.wr1_valid_i = 1'b1;
        bus.wr1_addr_i  = AW'(6);
        bus.wr1_data_i  = DW'(32'h44);
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("midrst_busy", DW'(busy), DW'(1));
        chk("midrst_rdy1", DW'(bus.wr1_ready_o), DW'(0));
        chk("midrst_rd_valid", DW'(bus.rd_valid_o), DW'(0));
        tick();
        push_sweep(NENT);
        push_wr(AW'(6), DW'(32'h44));
        rst_n = 1'b1;
        wait_sweep("reclear_len");
        bus.wr1_valid_i = 1'b0;
        rd(AW'(6));
        rd(AW'(2));
        rd(AW'(9));

        repeat (4) tick();
        chk("wr_queue_empty", DW'(wq.size()), DW'(0));
        chk("rd_queue_empty", DW'(rq.size()), DW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
